// File: rtl/keypad_matrix_driver.sv
// keypad_matrix_driver: 3x4 keypad emulator that holds a requested key closed against a column scanner.
// Defining KEYPAD_BOUNCE_EN adds LFSR-driven contact bounce around each valid press.
module keypad_matrix_driver #(
  parameter int HOLD_CYCLES   = 16,
  parameter int GAP_CYCLES    = 8,
  parameter int BOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] key_code,
  input  logic       key_valid,
  output logic       key_ready,
  input  logic [2:0] columns,
  output logic [3:0] rows,
  output logic       pressed,
  output logic       done,
  output logic       err
);
  localparam int MHG = HOLD_CYCLES > GAP_CYCLES ? HOLD_CYCLES : GAP_CYCLES;
  localparam int MAXC = MHG > BOUNCE_CYCLES ? MHG : BOUNCE_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  localparam logic [CW-1:0] H_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] G_LAST = CW'(GAP_CYCLES - 1);
  typedef enum logic [2:0] {
    IDLE, PRESS, GAP
`ifdef KEYPAD_BOUNCE_EN
    , BOUNCE_IN, BOUNCE_OUT
`endif
  } state_t;
  state_t state, nxt;
  logic [CW-1:0] cnt, cnt_d;
  logic [3:0] code;
  logic err_lat, pressed_d, done_d;
  logic [1:0] row, col;
  logic hit;
`ifdef KEYPAD_BOUNCE_EN
  localparam logic [CW-1:0] B_LAST = CW'(BOUNCE_CYCLES - 1);
  logic [7:0] lfsr, lfsr_d;
`endif
  assign key_ready = state == IDLE;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:
`ifdef KEYPAD_BOUNCE_EN
        if (key_valid) nxt = key_code > 4'd11 ? GAP : BOUNCE_IN;
      BOUNCE_IN: if (cnt == B_LAST) nxt = PRESS;
      PRESS: if (cnt == H_LAST) nxt = BOUNCE_OUT;
      BOUNCE_OUT: if (cnt == B_LAST) nxt = GAP;
`else
        if (key_valid) nxt = key_code > 4'd11 ? GAP : PRESS;
      PRESS: if (cnt == H_LAST) nxt = GAP;
`endif
      GAP: if (cnt == G_LAST) nxt = IDLE;
      default: nxt = IDLE;
    endcase
    cnt_d = (nxt != state || state == IDLE) ? '0 : cnt + CW'(1);
    done_d = state == GAP && nxt == IDLE;
`ifdef KEYPAD_BOUNCE_EN
    lfsr_d = (nxt == BOUNCE_IN || nxt == BOUNCE_OUT) ?
             {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]} : lfsr;
    pressed_d = nxt == BOUNCE_IN  ? (cnt_d == B_LAST || lfsr[0]) :
                nxt == BOUNCE_OUT ? (cnt_d != B_LAST && lfsr[0]) :
                nxt == PRESS;
`else
    pressed_d = nxt == PRESS;
`endif
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      code    <= '0;
      err_lat <= 1'b0;
      pressed <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
`ifdef KEYPAD_BOUNCE_EN
      lfsr    <= 8'hA5;
`endif
    end else begin
      state   <= nxt;
      cnt     <= cnt_d;
      pressed <= pressed_d;
      done    <= done_d;
      err     <= done_d && err_lat;
      if (state == IDLE && key_valid) begin
        code    <= key_code;
        err_lat <= key_code > 4'd11;
      end
`ifdef KEYPAD_BOUNCE_EN
      lfsr    <= lfsr_d;
`endif
    end
  end
  // Stored key to (row, column) position on the telephone layout
  always_comb begin
    case (code)
      4'd0:    {row, col} = {2'd3, 2'd1};
      4'd1:    {row, col} = {2'd0, 2'd0};
      4'd2:    {row, col} = {2'd0, 2'd1};
      4'd3:    {row, col} = {2'd0, 2'd2};
      4'd4:    {row, col} = {2'd1, 2'd0};
      4'd5:    {row, col} = {2'd1, 2'd1};
      4'd6:    {row, col} = {2'd1, 2'd2};
      4'd7:    {row, col} = {2'd2, 2'd0};
      4'd8:    {row, col} = {2'd2, 2'd1};
      4'd9:    {row, col} = {2'd2, 2'd2};
      4'd10:   {row, col} = {2'd3, 2'd0};
      4'd11:   {row, col} = {2'd3, 2'd2};
      default: {row, col} = {2'd0, 2'd0};
    endcase
  end
  assign hit  = pressed && col != 2'd3 && !columns[col];
  assign rows = ~(4'(hit) << row);
endmodule

// File: doc/keypad_matrix_driver.md
Name: keypad_matrix_driver

Overview:
- Synthesizable 3-column x 4-row telephone keypad emulator; the switch-matrix end of the keyscan interface.
- Accepts key codes over a valid/ready handshake and holds that switch closed for a programmed time.
- Pulls the matching row low while the keyscan drives that key's column low.
- Replaces a physical keypad in regression benches and FPGA demos of the clock.

Parameters:
HOLD_CYCLES, 16, clk cycles the contact stays closed per press (minimum 1)
GAP_CYCLES, 8, clk cycles of forced release after each press before the next code is accepted (minimum 1)
BOUNCE_CYCLES, 4, length of each bounce window; used only when KEYPAD_BOUNCE_EN is defined

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
key_code  input  4  key to press: 0-9 digits, 10 = '*', 11 = '#', 12-15 invalid
key_valid  input  1  key_code is valid this cycle
key_ready  output  1  high in IDLE only
columns  input  3  column drive from the scanner, active-low
rows  output  4  row sense to the scanner, active-low, idle 4'b1111
pressed  output  1  contact currently closed (registered)
done  output  1  one-cycle pulse when a press/gap sequence completes
err  output  1  one-cycle pulse, coincident with done, for a rejected invalid code

Behaviour:
- Reset (reset = 0, asynchronous): state = IDLE; counters = 0; pressed = 0; stored code = 0; done = 0; err = 0; rows = 4'b1111 immediately.
- Key map (row, column), row 0 = rows[0], column 0 = columns[0]:
  - Row 0: 1, 2, 3. Row 1: 4, 5, 6. Row 2: 7, 8, 9. Row 3: '*', 0, '#'.
  - Code 0 is therefore row 3, column 1.
- Rows are combinational from the registered press state and columns: rows[r] = 0 iff pressed = 1, r is the stored key's row, and columns[stored column] = 0.
  - Any number of columns may be low at once; no other path from columns to rows.
- Handshake: code accepted on a rising edge with key_valid = 1 and key_ready = 1. key_code is sampled into a register at acceptance. key_valid while key_ready = 0 is ignored (no queue).
- States:
  - IDLE: key_ready = 1. Valid code -> PRESS, pressed = 1 from the next cycle. Invalid code (12-15) -> GAP with pressed = 0, err flag latched.
  - PRESS: hold counter counts HOLD_CYCLES cycles; pressed = 1 for exactly HOLD_CYCLES cycles; then -> GAP, pressed = 0.
  - GAP: counter counts GAP_CYCLES cycles; on the last cycle -> IDLE.
  - GAP -> IDLE transition: done = 1 for one cycle; err = 1 on that same cycle if the code was invalid.
- Latency:
  - Valid code: acceptance edge to next key_ready = 1 is HOLD_CYCLES + GAP_CYCLES + 1 cycles.
  - Invalid code: GAP_CYCLES + 1 cycles.
- Counters: width = clog2(max(HOLD_CYCLES, GAP_CYCLES, BOUNCE_CYCLES) + 1). Load 0 on state entry; no wrap.
- Reset mid-press: contact opens asynchronously; no done or err is issued for the aborted press.
- key_code and key_valid changing mid-sequence have no effect.

Optional Feature:
- KEYPAD_BOUNCE_EN defined:
  - Adds states BOUNCE_IN (between IDLE and PRESS) and BOUNCE_OUT (between PRESS and GAP), each BOUNCE_CYCLES long.
  - During bounce, pressed follows bit 0 of an 8-bit Fibonacci LFSR, taps 8, 6, 5, 4, seed 8'hA5 at reset, stepped every cycle in the bounce states.
  - pressed is forced to 1 on the last BOUNCE_IN cycle and to 0 on the last BOUNCE_OUT cycle.
  - Latency grows by 2*BOUNCE_CYCLES for valid codes only.
- KEYPAD_BOUNCE_EN undefined: no bounce states, no LFSR; behaviour exactly as above.

Test Plan:
- Reset held then released, columns = 3'b000 -> rows = 4'b1111, key_ready = 1, pressed = 0, done = 0.
- Code 5, scan with columns = 3'b101 -> rows = 4'b1101 for exactly 16 cycles, otherwise 4'b1111; done one cycle at 25 cycles after acceptance.
- Code 0 with columns = 3'b011 -> rows stays 4'b1111 throughout; with columns = 3'b101 -> rows = 4'b0111 while pressed.
- Code 13 -> no row ever low, err = done = 1 on the same single cycle, key_ready back 9 cycles after acceptance.
- Code 9 accepted, second key_valid with code 1 during PRESS, then reset asserted at hold cycle 6 -> rows = 4'b1111 immediately, no done, code 1 never pressed, key_ready = 1 after release.
- KEYPAD_BOUNCE_EN build, code 12 -> no bounce, 9-cycle latency; code 3 -> pressed toggles per LFSR for 4 cycles, then steady 16 cycles; done at 33 cycles after acceptance.
